iso_rx_fifo_core: RTL and testbench

Parametrised ISO7816-3 character receiver with an internal ETU counter, a receive FIFO and T=0 error-signal (NACK) generation. It replaces the single-register receiver plus external bit-clock counter pairing. It sits between the synchronised card I/O line and the host register interface. The host pops characters from the FIFO and acknowledges sticky error flags.

---
 rtl/iso_rx_fifo_core.sv | 250 +++++++++++++++++++++++++
 tb/tb_iso_rx_fifo_core.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/iso_rx_fifo_core.sv
// iso_rx_fifo_core
// ISO7816-3 character receiver with its own ETU counter, a receive FIFO and
// T=0 error-signal (NACK) generation.
//
// Ports:
//   clk, nReset        - clock, asynchronous active-low reset
//   clocksPerBit       - clk cycles per ETU (>=4), latched at start detection
//   stopBit2           - two stop bits when 1, latched at start detection
//   oddParity          - parity sense (1: data+parity has odd number of ones)
//   msbFirst           - first data bit on the line is the MSB
//   nackEnable         - signal parity errors on the line and drop the char
//   serialIn           - asynchronous card I/O line
//   nackOut            - 1 pulls the I/O line low (error signal)
//   dataOut/dataValid  - FIFO head and non-empty indication
//   dataRead           - pop FIFO head (ignored when empty)
//   fifoLevel          - number of stored characters
//   parityErrorFlag, frameErrorFlag, overrunErrorFlag - sticky error flags
//   ackFlags           - clears the sticky flags (a simultaneous set wins)
//   startBit, run, endOfRx - frame status
module iso_rx_fifo_core #(
  parameter int   DATA_WIDTH          = 8,
  parameter int   CLOCK_PER_BIT_WIDTH = 13,
  parameter int   FIFO_DEPTH_LOG2     = 2,
  parameter logic START_BIT           = 1'b0
) (
  input  logic                           clk,
  input  logic                           nReset,
  input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
  input  logic                           stopBit2,
  input  logic                           oddParity,
  input  logic                           msbFirst,
  input  logic                           nackEnable,
  input  logic                           serialIn,
  output logic                           nackOut,
  output logic [DATA_WIDTH-1:0]          dataOut,
  output logic                           dataValid,
  input  logic                           dataRead,
  output logic [FIFO_DEPTH_LOG2:0]       fifoLevel,
  output logic                           parityErrorFlag,
  output logic                           frameErrorFlag,
  output logic                           overrunErrorFlag,
  input  logic                           ackFlags,
  output logic                           startBit,
  output logic                           run,
  output logic                           endOfRx
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int LVL_W = FIFO_DEPTH_LOG2 + 1;
  localparam int BC_W  = $clog2(DATA_WIDTH + 1);
  localparam int CNT_W = CLOCK_PER_BIT_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_NACK
  } state_t;

  state_t                   state_q, state_d;
  logic                     sync1_q, sync2_q, sync_prev_q;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         cpb_q, cpb_d;
  logic                     stop2_q, stop2_d;
  logic [DATA_WIDTH-1:0]    shift_q, shift_d;
  logic [BC_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic                     par_err_q, par_err_d;
  logic                     frm_err_q, frm_err_d;
  logic                     par_flag_q, par_flag_d;
  logic                     frm_flag_q, frm_flag_d;
  logic                     ovr_flag_q, ovr_flag_d;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];

  logic             line, sample, cnt_last, eor;
  logic             set_par, set_frm, set_ovr;
  logic             push, push_ok, pop, full;
  logic [CNT_W-1:0] cnt_nxt;

  assign line     = sync2_q;
  assign sample   = (cnt_q == (cpb_q >> 1));
  assign cnt_last = (cnt_q == cpb_q - 1'b1);
  assign cnt_nxt  = cnt_last ? '0 : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cpb_d     = cpb_q;
    stop2_d   = stop2_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    set_par   = 1'b0;
    set_frm   = 1'b0;
    eor       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // The cycle of detection counts as ETU count 0, so the counter
        // resumes at 1 on the following cycle.
        if (sync_prev_q == ~START_BIT && line == START_BIT) begin
          state_d   = S_START;
          cnt_d     = CNT_W'(1);
          cpb_d     = clocksPerBit;
          stop2_d   = stopBit2;
          bit_cnt_d = '0;
          par_err_d = 1'b0;
          frm_err_d = 1'b0;
        end
      end
      S_START: begin
        cnt_d = cnt_nxt;
        if (sample && line != START_BIT) state_d = S_IDLE;
        else if (cnt_last)               state_d = S_DATA;
      end
      S_DATA: begin
        cnt_d = cnt_nxt;
        if (sample) begin
          shift_d   = msbFirst ? {shift_q[DATA_WIDTH-2:0], line}
                               : {line, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (cnt_last && bit_cnt_q == BC_W'(DATA_WIDTH)) state_d = S_PARITY;
      end
      S_PARITY: begin
        cnt_d = cnt_nxt;
        if (sample) begin
          par_err_d = (^shift_q) ^ line ^ oddParity;
          set_par   = (^shift_q) ^ line ^ oddParity;
        end
        if (cnt_last) state_d = S_STOP1;
      end
      S_STOP1: begin
        cnt_d = cnt_nxt;
        if (sample) begin
          if (line != ~START_BIT) begin
            frm_err_d = 1'b1;
            set_frm   = 1'b1;
          end
          // Error signal is timed from the STOP1 sample, not from a bit
          // boundary, so the ETU counter restarts here.
          if (par_err_q && nackEnable) begin
            state_d = S_NACK;
            cnt_d   = '0;
          end
        end else if (cnt_last) begin
          if (stop2_q) state_d = S_STOP2;
          else begin
            eor     = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_STOP2: begin
        cnt_d = cnt_nxt;
        if (sample && line != ~START_BIT) begin
          frm_err_d = 1'b1;
          set_frm   = 1'b1;
        end
        if (cnt_last) begin
          eor     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_NACK: begin
        cnt_d = cnt_nxt;
        if (cnt_last) begin
          eor     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO control: a push into a full FIFO is accepted only when the head is
  // popped in the same cycle (the freed slot is the one being written).
  always_comb begin
    full     = (level_q == LVL_W'(DEPTH));
    pop      = dataRead && (level_q != '0);
    push     = eor && (state_q != S_NACK) && !frm_err_q;
    push_ok  = push && (!full || pop);
    set_ovr  = push && full && !pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      level_d = level_q + 1'b1;
    else if (!push_ok && pop) level_d = level_q - 1'b1;
    par_flag_d = set_par | (par_flag_q & ~ackFlags);
    frm_flag_d = set_frm | (frm_flag_q & ~ackFlags);
    ovr_flag_d = set_ovr | (ovr_flag_q & ~ackFlags);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= S_IDLE;
      sync1_q     <= ~START_BIT;
      sync2_q     <= ~START_BIT;
      sync_prev_q <= ~START_BIT;
      cnt_q       <= '0;
      cpb_q       <= '0;
      stop2_q     <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      par_flag_q  <= 1'b0;
      frm_flag_q  <= 1'b0;
      ovr_flag_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= serialIn;
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
      cnt_q       <= cnt_d;
      cpb_q       <= cpb_d;
      stop2_q     <= stop2_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      par_err_q   <= par_err_d;
      frm_err_q   <= frm_err_d;
      par_flag_q  <= par_flag_d;
      frm_flag_q  <= frm_flag_d;
      ovr_flag_q  <= ovr_flag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  assign nackOut          = (state_q == S_NACK);
  assign startBit         = (state_q == S_START);
  assign run              = state_q inside {S_DATA, S_PARITY, S_STOP1, S_STOP2, S_NACK};
  assign endOfRx          = eor;
  assign dataValid        = (level_q != '0);
  assign dataOut          = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign fifoLevel        = level_q;
  assign parityErrorFlag  = par_flag_q;
  assign frameErrorFlag   = frm_flag_q;
  assign overrunErrorFlag = ovr_flag_q;

endmodule

// File: tb/tb_iso_rx_fifo_core.sv
// Directed testbench for iso_rx_fifo_core (ETU = 16 clocks).
module tb_iso_rx_fifo_core;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        nReset;
  logic [12:0] clocksPerBit;
  logic        stopBit2, oddParity, msbFirst, nackEnable, serialIn;
  logic        nackOut, dataValid, dataRead, ackFlags;
  logic [7:0]  dataOut;
  logic [2:0]  fifoLevel;
  logic        parityErrorFlag, frameErrorFlag, overrunErrorFlag;
  logic        startBit, run, endOfRx;

  iso_rx_fifo_core #(
    .DATA_WIDTH(8), .CLOCK_PER_BIT_WIDTH(13), .FIFO_DEPTH_LOG2(2), .START_BIT(1'b0)
  ) dut (
    .clk(clk), .nReset(nReset), .clocksPerBit(clocksPerBit), .stopBit2(stopBit2),
    .oddParity(oddParity), .msbFirst(msbFirst), .nackEnable(nackEnable),
    .serialIn(serialIn), .nackOut(nackOut), .dataOut(dataOut), .dataValid(dataValid),
    .dataRead(dataRead), .fifoLevel(fifoLevel), .parityErrorFlag(parityErrorFlag),
    .frameErrorFlag(frameErrorFlag), .overrunErrorFlag(overrunErrorFlag),
    .ackFlags(ackFlags), .startBit(startBit), .run(run), .endOfRx(endOfRx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder sampled on the falling edge.
  int eor_total = 0, eor_cyc = 0, nack_total = 0, nack_first = 0;
  int dv_rise = 0, start_total = 0, run_total = 0;
  logic nack_prev = 1'b0, dv_prev = 1'b0;
  always @(negedge clk) begin
    if (endOfRx) begin eor_total++; eor_cyc = cyc; end
    if (nackOut) begin
      nack_total++;
      if (!nack_prev) nack_first = cyc;
    end
    nack_prev = nackOut;
    if (dataValid && !dv_prev) dv_rise = cyc;
    dv_prev = dataValid;
    if (startBit) start_total++;
    if (run) run_total++;
  end

  int vectors = 0, miscompares = 0;
  int frame_p, eor_b, nack_b, start_b, run_b;
  bit seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    eor_b = eor_total; nack_b = nack_total; start_b = start_total; run_b = run_total;
  endtask

  // Drives one character; frame_p is the cycle the start bit hits the pin.
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_lvl);
    logic p;
    step(4);
    snap();
    p = (^d) ^ oddParity ^ bad_par;
    frame_p = cyc;
    serialIn = 1'b0; step(CPB);
    for (int i = 0; i < 8; i++) begin
      serialIn = msbFirst ? d[7-i] : d[i];
      step(CPB);
    end
    serialIn = p; step(CPB);
    serialIn = stop_lvl; step(CPB);
    if (stopBit2) begin serialIn = stop_lvl; step(CPB); end
    serialIn = 1'b1;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, dataOut, exp);
    dataRead = 1'b1; step(1); dataRead = 1'b0;
  endtask

  task automatic ack();
    ackFlags = 1'b1; step(1); ackFlags = 1'b0;
  endtask

  initial begin
    nReset = 1'b0; clocksPerBit = 13'd16; stopBit2 = 1'b0; oddParity = 1'b0;
    msbFirst = 1'b0; nackEnable = 1'b1; serialIn = 1'b1; dataRead = 1'b0; ackFlags = 1'b0;
    step(3);
    check("rst_dataValid", dataValid, 0);
    check("rst_level", fifoLevel, 0);
    check("rst_status", {nackOut, startBit, run, endOfRx}, 0);
    check("rst_flags", {parityErrorFlag, frameErrorFlag, overrunErrorFlag}, 0);
    check("rst_dataOut", dataOut, 0);
    nReset = 1'b1;
    step(5);

    // Basic 0x3B, even parity, LSB first
    send_frame(8'h3B, 1'b0, 1'b1);
    step(8);
    check("t1_eor_count", eor_total - eor_b, 1);
    check("t1_eor_cyc", eor_cyc - frame_p, 177);
    check("t1_dv_rise", dv_rise - frame_p, 178);
    check("t1_data", dataOut, 8'h3B);
    check("t1_level", fifoLevel, 1);
    check("t1_flags", {parityErrorFlag, frameErrorFlag, overrunErrorFlag}, 0);
    pop_check("t1_pop", 8'h3B);
    check("t1_empty", {dataValid, fifoLevel}, 0);

    // 6-cycle glitch
    step(4); snap();
    serialIn = 1'b0; step(6); serialIn = 1'b1; step(30);
    check("gl_start_cycles", start_total - start_b, 8);
    check("gl_run", run_total - run_b, 0);
    check("gl_eor", eor_total - eor_b, 0);
    check("gl_level", fifoLevel, 0);
    check("gl_flags", {parityErrorFlag, frameErrorFlag, overrunErrorFlag}, 0);

    // Wrong parity 0x55 with NACK
    send_frame(8'h55, 1'b1, 1'b1);
    step(16);
    check("nk_first", nack_first - frame_p, 171);
    check("nk_len", nack_total - nack_b, 16);
    check("nk_eor_cyc", eor_cyc - frame_p, 186);
    check("nk_eor_count", eor_total - eor_b, 1);
    check("nk_level", fifoLevel, 0);
    check("nk_pflag", parityErrorFlag, 1);
    check("nk_fflag", frameErrorFlag, 0);
    ack();
    check("nk_ack", parityErrorFlag, 0);

    // Wrong parity without NACK
    nackEnable = 1'b0;
    send_frame(8'h55, 1'b1, 1'b1);
    step(8);
    check("pn_nack", nack_total - nack_b, 0);
    check("pn_eor_cyc", eor_cyc - frame_p, 177);
    check("pn_level", fifoLevel, 1);
    check("pn_pflag", parityErrorFlag, 1);
    pop_check("pn_data", 8'h55);
    ack();
    nackEnable = 1'b1;

    // Frame error: stop bit low
    send_frame(8'h3C, 1'b0, 1'b0);
    step(8);
    check("fe_fflag", frameErrorFlag, 1);
    check("fe_pflag", parityErrorFlag, 0);
    check("fe_eor", eor_total - eor_b, 1);
    check("fe_level", fifoLevel, 0);
    ack();
    check("fe_ack", frameErrorFlag, 0);

    // Overrun: five characters, no reads
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    send_frame(8'h33, 1'b0, 1'b1);
    send_frame(8'h44, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b1);
    step(4);
    check("ov_level", fifoLevel, 4);
    check("ov_flag", overrunErrorFlag, 1);
    pop_check("ov_pop0", 8'h11);
    pop_check("ov_pop1", 8'h22);
    pop_check("ov_pop2", 8'h33);
    pop_check("ov_pop3", 8'h44);
    check("ov_empty", {dataValid, fifoLevel}, 0);
    ack();
    check("ov_ack", overrunErrorFlag, 0);

    // Pop on the endOfRx cycle while full
    send_frame(8'hA1, 1'b0, 1'b1);
    send_frame(8'hA2, 1'b0, 1'b1);
    send_frame(8'hA3, 1'b0, 1'b1);
    send_frame(8'hA4, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (endOfRx) seen = 1'b1;
      else step(1);
    end
    check("pe_eor_seen", seen, 1);
    dataRead = 1'b1; step(1); dataRead = 1'b0;
    step(4);
    check("pe_ovr", overrunErrorFlag, 0);
    check("pe_level", fifoLevel, 4);
    pop_check("pe_pop0", 8'hA2);
    pop_check("pe_pop1", 8'hA3);
    pop_check("pe_pop2", 8'hA4);
    pop_check("pe_pop3", 8'hA5);
    check("pe_empty", fifoLevel, 0);

    // MSB first, two stop bits
    msbFirst = 1'b1; stopBit2 = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1);
    step(8);
    check("m2_eor_cyc", eor_cyc - frame_p, 193);
    check("m2_data", dataOut, 8'hA5);
    check("m2_level", fifoLevel, 1);

    // Reset in the middle of a frame, FIFO holding a character
    step(4);
    serialIn = 1'b0; step(40);
    check("mr_run_before", run, 1);
    nReset = 1'b0; #1;
    check("mr_status", {nackOut, startBit, run, endOfRx}, 0);
    check("mr_fifo", {dataValid, fifoLevel}, 0);
    check("mr_dataOut", dataOut, 0);
    check("mr_flags", {parityErrorFlag, frameErrorFlag, overrunErrorFlag}, 0);
    serialIn = 1'b1; step(3);
    nReset = 1'b1; step(5);
    check("mr_after", {run, startBit, fifoLevel}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
